// File: rtl/bank_scatter_16.sv
// bank_scatter_16: scatters LANES bank-tagged bytes per batch into 16 single-write-port byte
// banks, serialising same-bank lanes over successive rounds behind ready/valid backpressure.
module bank_scatter_16 #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*5-1:0]      in_sel,
  input  logic [LANES*ADDR_W-1:0] in_addr,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic [15:0]             bank_we,
  output logic [16*ADDR_W-1:0]    bank_addr,
  output logic [16*DATA_W-1:0]    bank_data,
  output logic                    busy,
  output logic [31:0]             stall_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]                   state_r;
  logic [0:0]                   state_nxt_s;
  logic [LANES-1:0]             pend_r;
  logic [LANES-1:0]             pend_nxt_s;
  logic [LANES-1:0]             fresh_pend_s;
  logic [LANES-1:0]             grant_s;
  logic [LANES-1:0][3:0]        lane_bank_r;
  logic [LANES-1:0][ADDR_W-1:0] lane_addr_r;
  logic [LANES-1:0][DATA_W-1:0] lane_data_r;
  logic [15:0]                  bank_we_s;
  logic [15:0]                  bank_we_r;
  logic [15:0][ADDR_W-1:0]      bank_addr_s;
  logic [15:0][ADDR_W-1:0]      bank_addr_r;
  logic [15:0][DATA_W-1:0]      bank_data_s;
  logic [15:0][DATA_W-1:0]      bank_data_r;
  logic [31:0]                  stall_cnt_r;
  logic                         in_ready_s;
  logic                         accept_s;
  logic                         stall_s;
  logic                         blocked_s;
  logic                         hit_s;

  // Decode which lanes of the incoming batch actually carry a byte
  always_comb begin
    fresh_pend_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      fresh_pend_s[i] = ~in_sel[5*i+4];
    end
  end

  // Per-bank arbitration: a pending lane wins unless a lower pending lane targets the same bank
  always_comb begin
    grant_s   = {LANES{1'b0}};
    blocked_s = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      blocked_s = 1'b0;
      for (int j = 0; j < i; j++) begin
        blocked_s = blocked_s | (pend_r[j] & (lane_bank_r[j] == lane_bank_r[i]));
      end
      grant_s[i] = pend_r[i] & ~blocked_s;
    end
  end

  // Handshake: the final round of a batch overlaps acceptance of the next one
  always_comb begin
    in_ready_s = (state_r == ST_IDLE) | ((pend_r & ~grant_s) == {LANES{1'b0}});
    accept_s   = in_valid & in_ready_s;
    stall_s    = in_valid & ~in_ready_s;
  end

  // Pending-lane bookkeeping and state transition
  always_comb begin
    if (accept_s) begin
      pend_nxt_s = fresh_pend_s;
    end else begin
      pend_nxt_s = pend_r & ~grant_s;
    end
    case (state_r)
      ST_IDLE:  state_nxt_s = (accept_s && (fresh_pend_s != {LANES{1'b0}})) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nxt_s = (pend_nxt_s != {LANES{1'b0}}) ? ST_ISSUE : ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Route granted lanes onto their banks; idle banks keep their last address and data
  always_comb begin
    bank_we_s   = 16'h0000;
    bank_addr_s = bank_addr_r;
    bank_data_s = bank_data_r;
    hit_s       = 1'b0;
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < LANES; i++) begin
        hit_s          = grant_s[i] & (lane_bank_r[i] == 4'(b));
        bank_we_s[b]   = bank_we_s[b] | hit_s;
        bank_addr_s[b] = hit_s ? lane_addr_r[i] : bank_addr_s[b];
        bank_data_s[b] = hit_s ? lane_data_r[i] : bank_data_s[b];
      end
    end
  end

  // Control state and batch holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pend_r      <= {LANES{1'b0}};
      lane_bank_r <= '0;
      lane_addr_r <= '0;
      lane_data_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      pend_r  <= pend_nxt_s;
      if (accept_s) begin
        for (int i = 0; i < LANES; i++) begin
          lane_bank_r[i] <= in_sel[5*i +: 4];
          lane_addr_r[i] <= in_addr[i*ADDR_W +: ADDR_W];
          lane_data_r[i] <= in_data[i*DATA_W +: DATA_W];
        end
      end else begin
        lane_bank_r <= lane_bank_r;
        lane_addr_r <= lane_addr_r;
        lane_data_r <= lane_data_r;
      end
    end
  end

  // Registered bank write port
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_we_r   <= 16'h0000;
      bank_addr_r <= '0;
      bank_data_r <= '0;
    end else begin
      bank_we_r   <= bank_we_s;
      bank_addr_r <= bank_addr_s;
      bank_data_r <= bank_data_s;
    end
  end

  // Saturating backpressure counter
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign busy      = (state_r == ST_ISSUE);
  assign bank_we   = bank_we_r;
  assign bank_addr = bank_addr_r;
  assign bank_data = bank_data_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_bank_scatter_16.sv
// Scoreboard bench for bank_scatter_16: a rank-based model predicts every write round,
// handshake wait and stall count; a monitor compares each observed bank write.
module tb_bank_scatter_16;
  localparam int LANES  = 4;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [LANES*5-1:0]      in_sel = '0;
  logic [LANES*ADDR_W-1:0] in_addr = '0;
  logic [LANES*DATA_W-1:0] in_data = '0;
  logic [15:0]             bank_we;
  logic [16*ADDR_W-1:0]    bank_addr;
  logic [16*DATA_W-1:0]    bank_data;
  logic                    busy;
  logic [31:0]             stall_cnt;

  bank_scatter_16 #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_addr(in_addr), .in_data(in_data),
    .bank_we(bank_we), .bank_addr(bank_addr), .bank_data(bank_data),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]          we;
    logic [16*ADDR_W-1:0] addr;
    logic [16*DATA_W-1:0] data;
  } exp_t;

  exp_t                 exp_q[$];
  exp_t                 mon_e;
  logic [16*ADDR_W-1:0] sh_addr = '0;
  logic [16*DATA_W-1:0] sh_data = '0;
  int                   checks = 0;
  int                   errors = 0;
  int                   cyc = 0;
  int                   acc_cyc = 0;
  int                   prev_k = 0;
  int                   stall_model = 0;
  bit                   mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every observed write round must match the oldest predicted round
  always @(negedge clk) begin
    if (mon_en && !rst && (bank_we !== 16'h0000)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: bank_we=%h, expected no write", bank_we);
      end else begin
        mon_e = exp_q.pop_front();
        chk("bank_we", 256'(bank_we), 256'(mon_e.we));
        chk("bank_addr", 256'(bank_addr), 256'(mon_e.addr));
        chk("bank_data", 256'(bank_data), 256'(mon_e.data));
      end
    end
  end

  // Model: a lane's round is the number of earlier non-empty lanes aimed at the same bank
  task automatic model(input logic [LANES*5-1:0] s, input logic [LANES*ADDR_W-1:0] a,
                       input logic [LANES*DATA_W-1:0] d, input bit push, output int k);
    int   rnd[LANES];
    int   b;
    exp_t e;
    k = 0;
    for (int i = 0; i < LANES; i++) begin
      rnd[i] = -1;
      if (!s[5*i+4]) begin
        rnd[i] = 0;
        for (int j = 0; j < i; j++)
          if (!s[5*j+4] && (s[5*j +: 4] == s[5*i +: 4])) rnd[i]++;
        if (rnd[i] + 1 > k) k = rnd[i] + 1;
      end
    end
    if (push) begin
      for (int r = 0; r < k; r++) begin
        e.we = 16'h0000;
        for (int i = 0; i < LANES; i++) begin
          if (rnd[i] == r) begin
            b = int'(s[5*i +: 4]);
            e.we[b] = 1'b1;
            sh_addr[b*ADDR_W +: ADDR_W] = a[i*ADDR_W +: ADDR_W];
            sh_data[b*DATA_W +: DATA_W] = d[i*DATA_W +: DATA_W];
          end
        end
        e.addr = sh_addr;
        e.data = sh_data;
        exp_q.push_back(e);
      end
    end
  endtask

  // Driver: present a batch, check the handshake wait against the model, then release
  task automatic send(input logic [LANES*5-1:0] s, input logic [LANES*ADDR_W-1:0] a,
                      input logic [LANES*DATA_W-1:0] d, input bit track, input string tag);
    int waits;
    int expw;
    int k;
    @(negedge clk);
    in_sel   = s;
    in_addr  = a;
    in_data  = d;
    in_valid = 1'b1;
    expw = prev_k - 1 - (cyc - acc_cyc);
    if (expw < 0) expw = 0;
    waits = 0;
    #1;
    while (!in_ready) begin
      waits++;
      if (waits > 20) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: in_ready low for %0d cycles, expected %0d", tag, waits, expw);
        finish_sim();
      end
      @(negedge clk);
      #1;
    end
    chk({tag, "_wait"}, 256'(waits), 256'(expw));
    stall_model += expw;
    model(s, a, d, track, k);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    prev_k   = k;
    in_valid = 1'b0;
    in_sel   = LANES*5'($urandom);
    in_addr  = LANES*ADDR_W'($urandom);
    in_data  = LANES*DATA_W'($urandom);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 60)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 256'(exp_q.size()), 256'(0));
  endtask

  logic [LANES*5-1:0]      s;
  logic [LANES*ADDR_W-1:0] a;
  logic [LANES*DATA_W-1:0] d;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bank_addr", 256'(bank_addr), 256'(0));
    chk("rst_bank_data", 256'(bank_data), 256'(0));
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_we", 256'(bank_we), 256'(0));
      chk("idle_ready", 256'(in_ready), 256'(1));
      chk("idle_busy", 256'(busy), 256'(0));
      chk("idle_stall", 256'(stall_cnt), 256'(0));
    end

    send({5'd3, 5'd2, 5'd1, 5'd0}, {4{9'd5}}, {8'hDD, 8'hCC, 8'hBB, 8'hAA}, 1'b1, "t2");
    drain("t2");
    send({4{5'd7}}, {9'd13, 9'd12, 9'd11, 9'd10}, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1, "t3");
    chk("t3_busy", 256'(busy), 256'(1));
    send({5'h10, 5'd4, 5'h10, 5'd4}, {9'd0, 9'd8, 9'd0, 9'd8}, {8'h00, 8'h02, 8'h00, 8'h01},
         1'b1, "t4");
    chk("t3_stall", 256'(stall_cnt), 256'(3));
    drain("t4");
    chk("t4_final", 256'(bank_data[4*DATA_W +: DATA_W]), 256'(8'h02));

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < LANES; i++) s[5*i +: 5] = 5'((4*n + i) % 16);
      a = LANES*ADDR_W'($urandom);
      d = LANES*DATA_W'($urandom);
      send(s, a, d, 1'b1, "t5");
    end
    drain("t5");
    send({4{5'h10}}, a, d, 1'b1, "empty");
    chk("empty_busy", 256'(busy), 256'(0));
    chk("empty_ready", 256'(in_ready), 256'(1));
    chk("stall_mid", 256'(stall_cnt), 256'(stall_model));

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < LANES; i++) begin
        if ($urandom_range(0, 4) == 0) s[5*i +: 5] = 5'h10;
        else if ($urandom_range(0, 1) == 0) s[5*i +: 5] = 5'($urandom_range(0, 3));
        else s[5*i +: 5] = 5'($urandom_range(0, 15));
      end
      a = LANES*ADDR_W'($urandom);
      d = LANES*DATA_W'($urandom);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      send(s, a, d, 1'b1, "rnd");
    end
    drain("rnd");
    chk("stall_rnd", 256'(stall_cnt), 256'(stall_model));

    mon_en = 1'b0;
    send({4{5'd7}}, {9'd13, 9'd12, 9'd11, 9'd10}, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b0, "t6");
    @(negedge clk);
    @(negedge clk);
    chk("t6_round1", 256'(bank_we), 256'(16'h0080));
    rst = 1'b1;
    @(negedge clk);
    chk("t6_we", 256'(bank_we), 256'(0));
    chk("t6_busy", 256'(busy), 256'(0));
    chk("t6_ready", 256'(in_ready), 256'(1));
    chk("t6_stall", 256'(stall_cnt), 256'(0));
    chk("t6_addr", 256'(bank_addr), 256'(0));
    rst = 1'b0;
    sh_addr = '0;
    sh_data = '0;
    stall_model = 0;
    prev_k = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t6_quiet", 256'(bank_we), 256'(0));
    end
    mon_en = 1'b1;
    send({5'd9, 5'd9, 5'd2, 5'd9}, {9'd1, 9'd2, 9'd3, 9'd4}, {8'h5A, 8'hA5, 8'h3C, 8'hC3},
         1'b1, "post");
    drain("post");
    chk("stall_final", 256'(stall_cnt), 256'(stall_model));
    finish_sim();
  end
endmodule
